button_encoder: RTL
===================

# button_encoder

Input-side front end for the game top level. Synchronises and debounces the four raw player buttons and converts one accepted press into a 3-bit area code with a single-cycle valid strobe. The area tracker consumes that code, and the LED and timer blocks consume the tracker's outputs. The block gates input on the game-enable `switch` and the `finish` flag, and locks out further presses until every button is released.

## Interface
Parameters:
- `DEBOUNCE`, default 16: consecutive stable cycles required to accept a level change; legal range 2..255.
- `CNT_W`, default 8: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE.

Ports:
- `clock`, input, 1: sole clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low. 0 resets on the next rising edge of `clock`.
- `switch`, input, 1: game enable. 1 means input is accepted.
- `finish`, input, 1: game over. 1 freezes input.
- `button`, input, 4: raw asynchronous buttons, active-high.
- `area_code`, output, 3: last accepted area. 0 means none; `button[i]` maps to i+1.
- `area_valid`, output, 1: one-cycle pulse when `area_code` takes a newly accepted press.
- `pressed`, output, 4: debounced button levels.
- `busy`, output, 1: 1 in LOCK state.

## Operation
- Synchroniser: two flops per button (`sync1`, `sync2`), reset to 0.
- Debounce, per button i:
  - If `sync2[i]` equals `pressed[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - If the counter equals DEBOUNCE-1 while still mismatched, `pressed[i]` toggles and the counter clears.
  - A mismatch lasting fewer than DEBOUNCE cycles leaves `pressed` unchanged.
- Edge detect: `rise = pressed & ~prev`, where `prev` is `pressed` registered one cycle.
- FSM states:
  - IDLE: any rise takes the lowest set index i. The block sets `area_code` = i+1, pulses `area_valid`, and goes to LOCK.
  - LOCK: ignores all rises. Goes to IDLE on the first cycle `pressed` == 0.
  - DISABLED: entered from any state when `switch`=0 or `finish`=1. No `area_valid` pulses.
  - Leaving DISABLED (`switch`=1 and `finish`=0): goes to LOCK if `pressed` != 0, otherwise IDLE. A button held through disable never produces a press.
- `area_code` rules:
  - Holds its value between accepted presses.
  - Cleared to 0 on any cycle with `switch`=0.
  - Frozen, not cleared, while `finish`=1 and `switch`=1.
- Simultaneous rises in IDLE: the lowest index wins; the others are discarded, not queued.
- Debounce and synchroniser logic keep running in every state, including DISABLED, so `pressed` is always current.

## Timing
- Reset values (`reset`=0 at a rising edge, from the following cycle):
  - State is IDLE (DISABLED from the next edge if `switch`=0 or `finish`=1).
  - `area_code`=0, `area_valid`=0, `pressed`=0, `busy`=0.
  - All counters, `sync`, and `prev` registers are 0.
- Reset mid-debounce or mid-LOCK discards all progress.
- Latency for a raw change first sampled at edge n:
  - `sync2` at n+1.
  - First mismatch counted at n+2.
  - `pressed` toggles at n+1+DEBOUNCE.
  - `area_valid`/`area_code` update at n+2+DEBOUNCE.
- `area_valid` is high for exactly one cycle per accepted press, and never in consecutive cycles.
- `busy` rises in the same cycle as `area_valid`. It falls one cycle after `pressed` becomes 0.
- `switch`=0 or `finish`=1 in the same cycle as a rise: the disable wins and no pulse is issued.

## Test plan
- Reset and basic press (DEBOUNCE=16): hold `reset`=0 for 2 cycles, then set `switch`=1 and `finish`=0. Raise `button`=0100 sampled at edge 0 → `area_code`=3 and `area_valid`=1 exactly at edge 18, for one cycle; `busy`=1 from then on.
- Glitch rejection: a `button[0]` pulse of 15 cycles → `pressed` stays 0 and no `area_valid`. A 16-cycle pulse → one `area_valid` with `area_code`=1.
- Simultaneous and lockout: raise `button`=1010 together → `area_code`=2 with one pulse. Release `button[1]` while holding `button[3]`, then re-press `button[1]` → no pulse. Release all → `busy`=0, then press `button[3]` → `area_code`=4.
- Disable while held: hold `button[2]` accepted (`area_code`=3). Set `switch`=0 → `area_code`=0 next cycle. Set `switch`=1 with the button still held → no pulse and `busy`=1. Release, then press `button[0]` → `area_code`=1.
- Finish freeze: with `area_code`=2, set `finish`=1 and press `button[3]` → no pulse and `area_code` stays 2. Clear `finish` with buttons released, then press `button[3]` → `area_code`=4.
- Reset mid-debounce: start a press, assert `reset`=0 at cycle 10 of debounce → all outputs 0. After release of reset with the button still held, `area_valid` arrives DEBOUNCE+2 cycles after the first post-reset sample.

Source files
------------

// File: rtl/button_encoder.sv
// Player button front end: synchronise, debounce and encode one accepted press
// into a 3-bit area code with a single-cycle valid strobe and release lockout.
module button_encoder #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       switch,
    input  logic       finish,
    input  logic [3:0] button,
    output logic [2:0] area_code,
    output logic       area_valid,
    output logic [3:0] pressed,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        DISABLED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       pressed_q, pressed_d;
    logic [3:0]       prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [2:0]       area_code_q, area_code_d;
    logic             area_valid_q, area_valid_d;
    logic [3:0]       rise;
    logic [2:0]       sel_code;
    logic             enabled;

    assign enabled = switch && !finish;
    assign rise    = pressed_q & ~prev_q;

    // A level change is accepted only after DEBOUNCE consecutive mismatched cycles.
    always_comb begin
        pressed_d = pressed_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    pressed_d[i] = ~pressed_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest set index wins on simultaneous rises.
    always_comb begin
        sel_code = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) begin
                sel_code = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enabled) begin
            state_d = DISABLED;
        end else begin
            case (state_q)
                IDLE:     if (rise != 4'b0000) state_d = LOCK;
                LOCK:     if (pressed_q == 4'b0000) state_d = IDLE;
                DISABLED: state_d = (pressed_q != 4'b0000) ? LOCK : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // The code is wiped when the game is switched off but only frozen at game over.
    always_comb begin
        busy         = (state_q == LOCK);
        area_valid_d = 1'b0;
        area_code_d  = area_code_q;
        if (!switch) begin
            area_code_d = 3'd0;
        end else if (enabled && state_q == IDLE && rise != 4'b0000) begin
            area_code_d  = sel_code;
            area_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pressed_q    <= '0;
            prev_q       <= '0;
            area_code_q  <= '0;
            area_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= button;
            sync2_q      <= sync1_q;
            pressed_q    <= pressed_d;
            prev_q       <= pressed_q;
            area_code_q  <= area_code_d;
            area_valid_q <= area_valid_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign area_code  = area_code_q;
    assign area_valid = area_valid_q;
    assign pressed    = pressed_q;

endmodule
